ps2_dir_decoder: RTL and testbench



---
 rtl/pacman_pkg.sv | 33 +++
 rtl/ps2_dir_lut.sv | 44 ++++
 rtl/ps2_dir_decoder.sv | 126 ++++++++++++
 tb/tb_ps2_dir_decoder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared constants for the Pacman PS/2 input path.
// Holds the direction encoding, the PS/2 set-2 scan codes the decoder cares
// about, and the decoder FSM state type.
package pacman_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  // Arrow keys, only meaningful after an E0 prefix.
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Letter keys, plain (non-extended) codes.
  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_D = 8'h23;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EXT       = 2'd1,
    ST_BREAK     = 2'd2,
    ST_EXT_BREAK = 2'd3
  } ps2_state_t;

endpackage

// File: rtl/ps2_dir_lut.sv
// Scan-code to direction lookup (combinational).
// Ports:
//   code  in  8  scan-code byte
//   ext   in  1  byte was preceded by an E0 prefix
//   hit   out 1  code is a direction key
//   dir   out 2  direction code when hit
// Build option: PS2_WASD_EN also maps W/S/A/D as plain codes.
module ps2_dir_lut
  import pacman_pkg::*;
(
  input  logic [7:0] code,
  input  logic       ext,
  output logic       hit,
  output logic [1:0] dir
);

  always_comb begin
    hit = 1'b0;
    dir = DIR_UP;
    if (ext) begin
      case (code)
        SC_UP:    begin hit = 1'b1; dir = DIR_UP;    end
        SC_DOWN:  begin hit = 1'b1; dir = DIR_DOWN;  end
        SC_LEFT:  begin hit = 1'b1; dir = DIR_LEFT;  end
        SC_RIGHT: begin hit = 1'b1; dir = DIR_RIGHT; end
        default:  ;
      endcase
    end
`ifdef PS2_WASD_EN
    else begin
      case (code)
        SC_W:    begin hit = 1'b1; dir = DIR_UP;    end
        SC_S:    begin hit = 1'b1; dir = DIR_DOWN;  end
        SC_A:    begin hit = 1'b1; dir = DIR_LEFT;  end
        SC_D:    begin hit = 1'b1; dir = DIR_RIGHT; end
        default: ;
      endcase
    end
`else
    // Arrow-only build: plain bytes never map to a direction.
`endif
  end

endmodule

// File: rtl/ps2_dir_decoder.sv
// PS/2 byte stream to Pacman direction commands.
// Parses make / break (F0) / extended (E0) sequences so releases and
// typematic repeats never produce a new-press pulse.
// Ports:
//   clock       in  1  system clock
//   resetn      in  1  synchronous active-low reset
//   key_data    in  8  scan-code byte, valid while key_strobe is high
//   key_strobe  in  1  byte arrival; only its rising edge is used
//   dir_valid   out 1  one-cycle pulse on a new direction press
//   dir         out 2  last pressed direction (0 up,1 down,2 left,3 right)
//   held        out 4  currently held directions, bit = direction code
//   err_cnt     out 8  saturating protocol-error count
// Build option: PS2_WASD_EN (handled inside ps2_dir_lut).
//
// state        | meaning
// ST_IDLE      | waiting for a new sequence
// ST_EXT       | E0 seen, waiting for code or F0
// ST_BREAK     | F0 seen, next byte is the released plain code
// ST_EXT_BREAK | E0 F0 seen, next byte is the released extended code
module ps2_dir_decoder
  import pacman_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] key_data,
  input  logic       key_strobe,
  output logic       dir_valid,
  output logic [1:0] dir,
  output logic [3:0] held,
  output logic [7:0] err_cnt
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  ps2_state_t    state, state_nxt;
  logic          strobe_q;
  logic [CW-1:0] tmo_cnt;
  logic          byte_evt;
  logic          do_make, do_break, err_inc, ext;
  logic          lut_hit;
  logic [1:0]    lut_dir;

  assign byte_evt = key_strobe & ~strobe_q;
  assign ext      = (state == ST_EXT) || (state == ST_EXT_BREAK);

  ps2_dir_lut u_lut (
    .code (key_data),
    .ext  (ext),
    .hit  (lut_hit),
    .dir  (lut_dir)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      strobe_q <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      strobe_q <= key_strobe;
      // Counter only advances while waiting inside a prefix sequence.
      if (byte_evt || state_nxt == ST_IDLE)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    do_make   = 1'b0;
    do_break  = 1'b0;
    err_inc   = 1'b0;
    if (byte_evt) begin
      // A byte arriving on the expiry cycle is parsed, not flagged.
      case (state)
        ST_IDLE: begin
          if (key_data == SC_EXT)        state_nxt = ST_EXT;
          else if (key_data == SC_BREAK) state_nxt = ST_BREAK;
          else                           do_make   = 1'b1;
        end
        ST_EXT: begin
          if (key_data == SC_BREAK)      state_nxt = ST_EXT_BREAK;
          else if (key_data == SC_EXT)   state_nxt = ST_EXT;
          else begin
            do_make   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          if (key_data == SC_BREAK) err_inc  = 1'b1;
          else                      do_break = 1'b1;
        end
      endcase
    end else if (state != ST_IDLE && tmo_cnt == TMO_LAST) begin
      state_nxt = ST_IDLE;
      err_inc   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      dir_valid <= 1'b0;
      dir       <= DIR_UP;
      held      <= 4'b0000;
      err_cnt   <= 8'd0;
    end else begin
      dir_valid <= 1'b0;
      // Typematic repeats of an already-held key are ignored.
      if (do_make && lut_hit && !held[lut_dir]) begin
        held[lut_dir] <= 1'b1;
        dir           <= lut_dir;
        dir_valid     <= 1'b1;
      end
      if (do_break && lut_hit)
        held[lut_dir] <= 1'b0;
      if (err_inc && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ps2_dir_decoder.sv
module tb_ps2_dir_decoder;
  logic       clock = 1'b0;
  logic       resetn;
  logic [7:0] key_data;
  logic       key_strobe;
  logic       dir_valid;
  logic [1:0] dir;
  logic [3:0] held;
  logic [7:0] err_cnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int pulse_cnt = 0;

  always #5 clock = ~clock;

  ps2_dir_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .key_data   (key_data),
    .key_strobe (key_strobe),
    .dir_valid  (dir_valid),
    .dir        (dir),
    .held       (held),
    .err_cnt    (err_cnt)
  );

  always @(posedge clock) begin
    #1;
    if (dir_valid) pulse_cnt++;
  end

  // Byte event is sampled on the posedge after the first negedge; returns
  // at the negedge following the edge after that.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    key_data = b;
    key_strobe = 1'b1;
    @(negedge clock);
    key_strobe = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    resetn = 1'b0; key_data = 8'h00; key_strobe = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk_cnt++; if (dir_valid !== 1'b0) $display("FAIL reset_dir_valid got %0h exp 0", dir_valid); else pass_cnt++;
    chk_cnt++; if (dir !== 2'd0) $display("FAIL reset_dir got %0d exp 0", dir); else pass_cnt++;
    chk_cnt++; if (held !== 4'b0000) $display("FAIL reset_held got %b exp 0000", held); else pass_cnt++;
    chk_cnt++; if (err_cnt !== 8'd0) $display("FAIL reset_err got %0d exp 0", err_cnt); else pass_cnt++;
  endtask

  task automatic test_press_release();
    int p0;
    p0 = pulse_cnt;
    send_byte(8'hE0);
    @(negedge clock);
    key_data = 8'h75; key_strobe = 1'b1;
    @(negedge clock);
    chk_cnt++; if (dir_valid !== 1'b1) $display("FAIL up_pulse_high got %0h exp 1", dir_valid); else pass_cnt++;
    chk_cnt++; if (dir !== 2'd0) $display("FAIL up_dir got %0d exp 0", dir); else pass_cnt++;
    chk_cnt++; if (held !== 4'b0001) $display("FAIL up_held got %b exp 0001", held); else pass_cnt++;
    key_strobe = 1'b0;
    @(negedge clock);
    chk_cnt++; if (dir_valid !== 1'b0) $display("FAIL up_pulse_drop got %0h exp 0", dir_valid); else pass_cnt++;
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    chk_cnt++; if (held !== 4'b0000) $display("FAIL up_release_held got %b exp 0000", held); else pass_cnt++;
    chk_cnt++; if (dir !== 2'd0) $display("FAIL up_release_dir got %0d exp 0", dir); else pass_cnt++;
    chk_cnt++; if (pulse_cnt - p0 !== 1) $display("FAIL up_pulses got %0d exp 1", pulse_cnt - p0); else pass_cnt++;
  endtask

  task automatic test_typematic();
    int p0;
    p0 = pulse_cnt;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hE0); send_byte(8'h6B);
    end
    chk_cnt++; if (pulse_cnt - p0 !== 1) $display("FAIL typematic_pulses got %0d exp 1", pulse_cnt - p0); else pass_cnt++;
    chk_cnt++; if (dir !== 2'd2) $display("FAIL typematic_dir got %0d exp 2", dir); else pass_cnt++;
    chk_cnt++; if (held !== 4'b0100) $display("FAIL typematic_held got %b exp 0100", held); else pass_cnt++;
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    chk_cnt++; if (held !== 4'b0000) $display("FAIL typematic_release got %b exp 0000", held); else pass_cnt++;
  endtask

  task automatic test_overlap();
    send_byte(8'hE0); send_byte(8'h74);
    chk_cnt++; if (dir !== 2'd3) $display("FAIL ovl_right_dir got %0d exp 3", dir); else pass_cnt++;
    send_byte(8'hE0); send_byte(8'h75);
    chk_cnt++; if (dir !== 2'd0) $display("FAIL ovl_up_dir got %0d exp 0", dir); else pass_cnt++;
    chk_cnt++; if (held !== 4'b1001) $display("FAIL ovl_both_held got %b exp 1001", held); else pass_cnt++;
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    chk_cnt++; if (held !== 4'b1000) $display("FAIL ovl_rel_up_held got %b exp 1000", held); else pass_cnt++;
    chk_cnt++; if (dir !== 2'd0) $display("FAIL ovl_rel_up_dir got %0d exp 0", dir); else pass_cnt++;
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    chk_cnt++; if (held !== 4'b0000) $display("FAIL ovl_rel_right_held got %b exp 0000", held); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int p0;
    send_byte(8'hE0);
    repeat (14) @(negedge clock);
    chk_cnt++; if (err_cnt !== 8'd0) $display("FAIL tmo_early got %0d exp 0", err_cnt); else pass_cnt++;
    @(negedge clock);
    chk_cnt++; if (err_cnt !== 8'd1) $display("FAIL tmo_fire got %0d exp 1", err_cnt); else pass_cnt++;
    p0 = pulse_cnt;
    send_byte(8'h72);
    chk_cnt++; if (pulse_cnt - p0 !== 0) $display("FAIL tmo_plain72_pulses got %0d exp 0", pulse_cnt - p0); else pass_cnt++;
    chk_cnt++; if (held !== 4'b0000) $display("FAIL tmo_plain72_held got %b exp 0000", held); else pass_cnt++;
    send_byte(8'hE0);
    repeat (13) @(negedge clock);
    p0 = pulse_cnt;
    send_byte(8'h72);
    chk_cnt++; if (err_cnt !== 8'd1) $display("FAIL tmo_edge_err got %0d exp 1", err_cnt); else pass_cnt++;
    chk_cnt++; if (dir !== 2'd1) $display("FAIL tmo_edge_dir got %0d exp 1", dir); else pass_cnt++;
    chk_cnt++; if (held !== 4'b0010) $display("FAIL tmo_edge_held got %b exp 0010", held); else pass_cnt++;
    chk_cnt++; if (pulse_cnt - p0 !== 1) $display("FAIL tmo_edge_pulses got %0d exp 1", pulse_cnt - p0); else pass_cnt++;
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h72);
    chk_cnt++; if (held !== 4'b0000) $display("FAIL tmo_edge_release got %b exp 0000", held); else pass_cnt++;
  endtask

  task automatic test_break_error();
    int p0;
    send_byte(8'hF0); send_byte(8'hF0);
    chk_cnt++; if (err_cnt !== 8'd2) $display("FAIL brk_err got %0d exp 2", err_cnt); else pass_cnt++;
    p0 = pulse_cnt;
    send_byte(8'hE0); send_byte(8'h74);
    chk_cnt++; if (pulse_cnt - p0 !== 1) $display("FAIL brk_recover_pulses got %0d exp 1", pulse_cnt - p0); else pass_cnt++;
    chk_cnt++; if (dir !== 2'd3) $display("FAIL brk_recover_dir got %0d exp 3", dir); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int p0;
    send_byte(8'hE0); send_byte(8'hF0);
    @(negedge clock); resetn = 1'b0;
    @(negedge clock); resetn = 1'b1;
    chk_cnt++; if (held !== 4'b0000) $display("FAIL rstmid_held got %b exp 0000", held); else pass_cnt++;
    chk_cnt++; if (dir !== 2'd0) $display("FAIL rstmid_dir got %0d exp 0", dir); else pass_cnt++;
    chk_cnt++; if (err_cnt !== 8'd0) $display("FAIL rstmid_err got %0d exp 0", err_cnt); else pass_cnt++;
    chk_cnt++; if (dir_valid !== 1'b0) $display("FAIL rstmid_valid got %0h exp 0", dir_valid); else pass_cnt++;
    p0 = pulse_cnt;
    send_byte(8'hE0); send_byte(8'h72);
    chk_cnt++; if (dir !== 2'd1) $display("FAIL rstmid_down_dir got %0d exp 1", dir); else pass_cnt++;
    chk_cnt++; if (held !== 4'b0010) $display("FAIL rstmid_down_held got %b exp 0010", held); else pass_cnt++;
    chk_cnt++; if (pulse_cnt - p0 !== 1) $display("FAIL rstmid_down_pulses got %0d exp 1", pulse_cnt - p0); else pass_cnt++;
    chk_cnt++; if (err_cnt !== 8'd0) $display("FAIL rstmid_down_err got %0d exp 0", err_cnt); else pass_cnt++;
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h72);
  endtask

  task automatic test_wasd();
    int p0;
    logic [1:0] exp_dir;
    logic [3:0] exp_held;
    int exp_pulses;
`ifdef PS2_WASD_EN
    exp_dir = 2'd2; exp_held = 4'b0100; exp_pulses = 1;
`else
    exp_dir = 2'd1; exp_held = 4'b0000; exp_pulses = 0;
`endif
    p0 = pulse_cnt;
    send_byte(8'h1C);
    chk_cnt++; if (dir !== exp_dir) $display("FAIL wasd_a_dir got %0d exp %0d", dir, exp_dir); else pass_cnt++;
    chk_cnt++; if (held !== exp_held) $display("FAIL wasd_a_held got %b exp %b", held, exp_held); else pass_cnt++;
    chk_cnt++; if (pulse_cnt - p0 !== exp_pulses) $display("FAIL wasd_a_pulses got %0d exp %0d", pulse_cnt - p0, exp_pulses); else pass_cnt++;
    // Releasing the arrow clears a bit set by the letter key.
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    chk_cnt++; if (held !== 4'b0000) $display("FAIL wasd_shared_release got %b exp 0000", held); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    send_byte(8'hE0); send_byte(8'h75);
    chk_cnt++; if (held !== 4'b0001) $display("FAIL level_press_held got %b exp 0001", held); else pass_cnt++;
    send_byte(8'hE0);
    @(negedge clock);
    key_data = 8'hF0; key_strobe = 1'b1;
    repeat (4) @(negedge clock);
    key_strobe = 1'b0;
    @(negedge clock);
    send_byte(8'h75);
    chk_cnt++; if (held !== 4'b0000) $display("FAIL level_release_held got %b exp 0000", held); else pass_cnt++;
    chk_cnt++; if (err_cnt !== 8'd0) $display("FAIL level_err got %0d exp 0", err_cnt); else pass_cnt++;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 260; i++) begin
      send_byte(8'hF0); send_byte(8'hF0);
      if (i == 99) begin
        chk_cnt++; if (err_cnt !== 8'd100) $display("FAIL sat_mid got %0d exp 100", err_cnt); else pass_cnt++;
      end
    end
    chk_cnt++; if (err_cnt !== 8'd255) $display("FAIL sat_top got %0d exp 255", err_cnt); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_typematic();
    test_overlap();
    test_timeout();
    test_break_error();
    test_reset_mid();
    test_wasd();
    test_back_to_back();
    test_saturate();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
